mem_port_sched: RTL and testbench
=================================

Name: mem_port_sched

Overview:
- Schedules the single shared memory port between the DLX instruction-fetch stage and the data (load/store) stage.
- Latches one request at a time and drives the memory handshake.
- Returns read data and a one-cycle response pulse to the granted requester; the other requester stalls.
- Generates big-endian byte enables for byte, halfword and word accesses.
- Aborts any access the memory does not complete within a timeout.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; fixed at 32 because the byte-enable logic assumes 4 lanes.
- TIMEOUT_CYC, 255, maximum cycles in BUSY before the access is aborted; legal range 1..1023.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_valid.
- if_addr  in  ADDR_W  fetch address; must be word aligned.
- if_valid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_W  fetched instruction.
- if_stall  out  1  if_req && !if_valid.
- d_req  in  1  data request; held stable until d_valid.
- d_wr  in  1  1 = store, 0 = load.
- d_size  in  2  00 byte, 01 half, 10 word; 11 illegal.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data, right-justified.
- d_valid  out  1  one-cycle response pulse.
- d_rdata  out  DATA_W  raw 32-bit memory word; extraction is done downstream.
- d_err  out  1  qualifies d_valid: misaligned, illegal size, or timeout.
- d_stall  out  1  d_req && !d_valid.
- mem_req  out  1  memory access strobe; registered.
- mem_wr  out  1  write strobe.
- mem_addr  out  ADDR_W  word address; low 2 bits forced to 0.
- mem_be  out  4  byte enables; bit 3 = offset 0 (bits 31:24), bit 0 = offset 3.
- mem_wdata  out  DATA_W  lane-replicated store data.
- mem_rdata  in  DATA_W  read data; sampled when mem_ready=1.
- mem_ready  in  1  access complete; may be high in the first BUSY cycle.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0; rr_last 0.
- Reset asserted mid-access drops mem_req the next cycle and emits no response.
- FSM states: IDLE, BUSY, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, d_req=1: grant data (data has priority over fetch by default).
  - If the access is misaligned (half with addr[0]=1; word with addr[1:0]≠0) or d_size=11: go to RESP with err=1; mem_req is never asserted.
  - Otherwise latch address, wr, be and wdata; go to BUSY.
- IDLE, only if_req=1: latch the fetch; be=1111, wr=0; go to BUSY.
- BUSY:
  - mem_req=1 and outputs held stable; counter increments each cycle.
  - mem_ready=1: capture mem_rdata, go to RESP.
  - Counter reaches TIMEOUT_CYC without mem_ready: drop mem_req, go to RESP with err=1 (fetch timeout: if_valid with if_rdata=0; data timeout: d_err=1).
- RESP: pulse the granted requester's valid for one cycle; return to IDLE.
- Minimum latency: request at cycle 0, mem_req at cycle 1, mem_ready at cycle 1, valid at cycle 2.
- Minimum spacing between grants: 3 cycles.
- Requests dropped before a grant are ignored. A requester that drops req after grant still receives its pulse.
- Byte enables:
  - byte: one-hot on lane addr[1:0] (offset 0 → 1000).
  - half: addr[1]=0 → 1100, addr[1]=1 → 0011.
  - word: 1111.
- Store data lanes: byte replicated ×4; half replicated ×2.
- Simultaneous if_req and d_req in IDLE: data wins; fetch keeps stalling.

Optional Feature:
- Macro: MEM_SCHED_RR_EN.
- Defined: round-robin arbitration.
  - rr_last records the last granted source.
  - On simultaneous requests, the source not granted last wins; a single requester always wins.
- Undefined: fixed data priority; rr_last is absent.

Decomposition:
- Package dlx_mem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - FSM state encoding;
  - source enum SRC_IF, SRC_D.
- Sub-module mem_lane_gen is combinational: size + addr[1:0] + wdata → be, replicated wdata, misalign flag.

Test Plan:
- Fetch only: if_addr=0x100, mem_ready tied 1, mem_rdata=0x20010005 → mem_req in cycle 1, if_valid at cycle 2 with if_rdata=0x20010005; if_stall high in cycles 0–1.
- Concurrent requests, default build: both requests in cycle 0, d_wr=1 (store), d_size=00, d_addr=0x203, d_wdata=0xAB → data granted first with mem_be=0001, mem_wdata=0xABABABAB, mem_addr=0x200; fetch granted after RESP.
- Misaligned access: d_size=10, d_addr=0x102 → d_valid+d_err two cycles after request; mem_req never asserted.
- Timeout: TIMEOUT_CYC=4, mem_ready held 0 → mem_req high exactly 4 cycles; d_valid+d_err 1 cycle later.
- Reset mid-BUSY: reset asserted in the 2nd BUSY cycle → all outputs 0 the next cycle; no valid pulse; a fresh request afterwards completes normally.
- MEM_SCHED_RR_EN defined, both requesters held high for 4 grants → grant order D, IF, D, IF.

Source files
------------

// File: rtl/dlx_mem_pkg.sv
// rtl/dlx_mem_pkg.sv - shared encodings for the DLX memory-port scheduler
package dlx_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Wide enough for the largest legal TIMEOUT_CYC (1023)
  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_D  = 1'b1
  } src_e;

endpackage

// File: rtl/mem_lane_gen.sv
// rtl/mem_lane_gen.sv - big-endian byte enables, store-lane replication and misalign detect
module mem_lane_gen
  import dlx_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misalign
);

  // Lane 0 (addr offset 0) is the most significant byte, so enables shift right with offset
  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    misalign  = 1'b0;
    case (size)
      SZ_BYTE: begin
        be        = 4'b1000 >> addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be        = addr_lo[1] ? 4'b0011 : 4'b1100;
        wdata_rep = {2{wdata[15:0]}};
        misalign  = addr_lo[0];
      end
      SZ_WORD: begin
        be        = 4'b1111;
        misalign  = (addr_lo != 2'b00);
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_port_sched.sv
// rtl/mem_port_sched.sv - fetch/data arbiter for one memory port; MEM_SCHED_RR_EN selects round-robin
module mem_port_sched
  import dlx_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  state_e           state;
  src_e             src;
  logic             pend_err;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       d_be;
  logic [31:0]      d_wrep;
  logic             d_mis;
  logic             grant_d;
  logic             grant_if;
  logic             done;

  mem_lane_gen u_lane (
    .size      (d_size),
    .addr_lo   (d_addr[1:0]),
    .wdata     (d_wdata),
    .be        (d_be),
    .wdata_rep (d_wrep),
    .misalign  (d_mis)
  );

`ifdef MEM_SCHED_RR_EN
  src_e rr_last;

  always_comb begin
    grant_d  = d_req && (!if_req || (rr_last == SRC_IF));
    grant_if = if_req && !grant_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last <= SRC_IF;
    end else if (state == ST_IDLE && (grant_d || grant_if)) begin
      rr_last <= grant_d ? SRC_D : SRC_IF;
    end
  end
`else
  assign grant_d  = d_req;
  assign grant_if = if_req && !d_req;
`endif

  assign if_stall = if_req && !if_valid;
  assign d_stall  = d_req && !d_valid;
  assign done     = mem_ready || (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      src       <= SRC_IF;
      pend_err  <= 1'b0;
      cnt       <= '0;
      if_valid  <= 1'b0;
      if_rdata  <= '0;
      d_valid   <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= '0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      d_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (grant_d) begin
            src <= SRC_D;
            if (d_mis) begin
              pend_err <= 1'b1;
              state    <= ST_RESP;
            end else begin
              mem_req   <= 1'b1;
              mem_wr    <= d_wr;
              mem_addr  <= d_addr & WORD_MASK;
              mem_be    <= d_be;
              mem_wdata <= d_wrep;
              state     <= ST_BUSY;
            end
          end else if (grant_if) begin
            src       <= SRC_IF;
            mem_req   <= 1'b1;
            mem_wr    <= 1'b0;
            mem_addr  <= if_addr & WORD_MASK;
            mem_be    <= 4'b1111;
            mem_wdata <= '0;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          cnt <= cnt + 1'b1;
          if (done) begin
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
            state     <= ST_RESP;
            if (src == SRC_D) begin
              d_valid <= 1'b1;
              d_err   <= !mem_ready;
              d_rdata <= mem_ready ? mem_rdata : '0;
            end else begin
              if_valid <= 1'b1;
              if_rdata <= mem_ready ? mem_rdata : '0;
            end
          end
        end
        ST_RESP: begin
          // Rejected data accesses spend one extra RESP cycle so error latency matches a 1-cycle access
          if (pend_err) begin
            pend_err <= 1'b0;
            d_valid  <= 1'b1;
            d_err    <= 1'b1;
            d_rdata  <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_sched.sv
// tb/tb_mem_port_sched.sv - directed self-checking bench for mem_port_sched
module tb_mem_port_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        d_req;
  logic        d_wr;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        d_stall;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;

  mem_port_sched #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err), .d_stall(d_stall),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    checks++; if (if_valid !== 1'b0 || d_valid !== 1'b0 || d_err !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b%b%b want 000", if_valid, d_valid, d_err); end
    checks++; if (mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0 || mem_wr !== 1'b0) begin
      errors++; $display("FAIL reset_mem_bus got addr %h be %b wd %h wr %b want zeros", mem_addr, mem_be, mem_wdata, mem_wr); end
    checks++; if (if_stall !== 1'b0 || d_stall !== 1'b0 || if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_misc got stall %b%b ird %h drd %h want zeros", if_stall, d_stall, if_rdata, d_rdata); end
    reset = 1'b0;
  endtask

  task automatic test_fetch;
    mem_ready = 1'b1;
    mem_rdata = 32'h2001_0005;
    if_addr = 32'h100;
    if_req = 1'b1;
    #1;
    checks++; if (if_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_c0 got %b want 1", if_stall); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_be !== 4'b1111 || mem_wr !== 1'b0) begin
      errors++; $display("FAIL fetch_mem_c1 got req %b addr %h be %b wr %b want 1 100 1111 0", mem_req, mem_addr, mem_be, mem_wr); end
    checks++; if (if_stall !== 1'b1 || if_valid !== 1'b0) begin
      errors++; $display("FAIL fetch_stall_c1 got stall %b valid %b want 1 0", if_stall, if_valid); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h2001_0005) begin
      errors++; $display("FAIL fetch_resp_c2 got valid %b data %h want 1 20010005", if_valid, if_rdata); end
    checks++; if (if_stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL fetch_c2_flags got stall %b mem_req %b want 0 0", if_stall, mem_req); end
    if_req = 1'b0;
    tick();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL fetch_pulse_len got %b want 0", if_valid); end
  endtask

  task automatic test_concurrent;
    mem_ready = 1'b1;
    mem_rdata = 32'h1122_3344;
    if_addr = 32'h100;
    if_req = 1'b1;
    d_req = 1'b1; d_wr = 1'b1; d_size = 2'b00; d_addr = 32'h203; d_wdata = 32'h0000_00AB;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_be !== 4'b0001 || mem_wdata !== 32'hABAB_ABAB || mem_addr !== 32'h200) begin
      errors++; $display("FAIL conc_data_grant got req %b wr %b be %b wd %h addr %h want 1 1 0001 abababab 200",
                         mem_req, mem_wr, mem_be, mem_wdata, mem_addr); end
    tick();
    checks++; if (d_valid !== 1'b1 || d_err !== 1'b0 || if_valid !== 1'b0 || if_stall !== 1'b1) begin
      errors++; $display("FAIL conc_data_resp got dv %b de %b iv %b is %b want 1 0 0 1", d_valid, d_err, if_valid, if_stall); end
    d_req = 1'b0;
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL conc_gap got mem_req %b want 0", mem_req); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'h100 || mem_be !== 4'b1111) begin
      errors++; $display("FAIL conc_fetch_grant got req %b wr %b addr %h be %b want 1 0 100 1111", mem_req, mem_wr, mem_addr, mem_be); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h1122_3344) begin
      errors++; $display("FAIL conc_fetch_resp got valid %b data %h want 1 11223344", if_valid, if_rdata); end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_lanes;
    logic [1:0]  sz [4] = '{2'b00, 2'b01, 2'b01, 2'b10};
    logic [31:0] ad [4] = '{32'h400, 32'h402, 32'h404, 32'h408};
    logic [31:0] wd [4] = '{32'h0000_005A, 32'h0000_1234, 32'hFFFF_BEEF, 32'hDEAD_BEEF};
    logic [3:0]  be [4] = '{4'b1000, 4'b0011, 4'b1100, 4'b1111};
    logic [31:0] rp [4] = '{32'h5A5A_5A5A, 32'h1234_1234, 32'hBEEF_BEEF, 32'hDEAD_BEEF};
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_rdata = 32'hC000_0000 + 32'(i);
      d_req = 1'b1; d_wr = 1'b1; d_size = sz[i]; d_addr = ad[i]; d_wdata = wd[i];
      tick();
      checks++; if (mem_be !== be[i] || mem_wdata !== rp[i] || mem_addr !== (ad[i] & 32'hFFFF_FFFC)) begin
        errors++; $display("FAIL lanes_%0d got be %b wd %h addr %h want %b %h %h", i, mem_be, mem_wdata, mem_addr,
                           be[i], rp[i], ad[i] & 32'hFFFF_FFFC); end
      tick();
      checks++; if (d_valid !== 1'b1 || d_err !== 1'b0 || d_rdata !== 32'hC000_0000 + 32'(i)) begin
        errors++; $display("FAIL lanes_resp_%0d got dv %b de %b rd %h want 1 0 %h", i, d_valid, d_err, d_rdata,
                           32'hC000_0000 + 32'(i)); end
      d_req = 1'b0;
      tick();
    end
  endtask

  task automatic test_misaligned;
    logic [1:0]  sz [3] = '{2'b10, 2'b11, 2'b01};
    logic [31:0] ad [3] = '{32'h102, 32'h100, 32'h105};
    int          req_seen;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_seen = 0;
      d_req = 1'b1; d_wr = 1'b0; d_size = sz[i]; d_addr = ad[i];
      tick();
      if (mem_req) req_seen++;
      checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL mis_early_%0d got d_valid %b want 0", i, d_valid); end
      tick();
      if (mem_req) req_seen++;
      checks++; if (d_valid !== 1'b1 || d_err !== 1'b1) begin
        errors++; $display("FAIL mis_resp_%0d got dv %b de %b want 1 1", i, d_valid, d_err); end
      d_req = 1'b0;
      tick();
      if (mem_req) req_seen++;
      checks++; if (req_seen !== 0) begin errors++; $display("FAIL mis_no_mem_%0d got %0d mem_req cycles want 0", i, req_seen); end
    end
  endtask

  task automatic test_timeout;
    int req_cycles = 0;
    int resp_cycle = -1;
    mem_ready = 1'b0;
    d_req = 1'b1; d_wr = 1'b0; d_size = 2'b10; d_addr = 32'h40;
    for (int c = 1; c <= 20 && resp_cycle < 0; c++) begin
      tick();
      if (mem_req) req_cycles++;
      if (d_valid) begin
        resp_cycle = c;
        checks++; if (d_err !== 1'b1 || d_rdata !== 32'h0 || mem_req !== 1'b0) begin
          errors++; $display("FAIL timeout_resp got de %b rd %h mem_req %b want 1 0 0", d_err, d_rdata, mem_req); end
      end
    end
    d_req = 1'b0;
    checks++; if (resp_cycle != 5) begin errors++; $display("FAIL timeout_latency got cycle %0d want 5", resp_cycle); end
    checks++; if (req_cycles != 4) begin errors++; $display("FAIL timeout_mem_req_len got %0d want 4", req_cycles); end
    tick();
    tick();
  endtask

  task automatic test_reset_mid;
    int spurious = 0;
    mem_ready = 1'b0;
    if_addr = 32'h80;
    if_req = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b0 || mem_be !== 4'h0 || mem_addr !== 32'h0 || if_valid !== 1'b0 || d_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs got req %b be %b addr %h iv %b dv %b want zeros", mem_req, mem_be, mem_addr, if_valid, d_valid); end
    reset = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    if (if_valid) spurious++;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin
      errors++; $display("FAIL rstmid_regrant got req %b addr %h want 1 80", mem_req, mem_addr); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_rdata !== 32'hCAFE_F00D || spurious != 0) begin
      errors++; $display("FAIL rstmid_fresh got iv %b rd %h spurious %0d want 1 cafef00d 0", if_valid, if_rdata, spurious); end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    logic [3:0] got = 4'b0000;
    logic [3:0] want;
    int         g = 0;
    int         last_c = -1;
    int         bad_gap = 0;
`ifdef MEM_SCHED_RR_EN
    want = 4'b0101;
`else
    want = 4'b1111;
`endif
    mem_ready = 1'b1;
    mem_rdata = 32'h0;
    if_addr = 32'h100;
    d_wr = 1'b0; d_size = 2'b10; d_addr = 32'h300;
    if_req = 1'b1;
    d_req = 1'b1;
    for (int c = 1; c <= 40 && g < 4; c++) begin
      tick();
      if (mem_req) begin
        got[g] = (mem_addr == 32'h300);
        if (last_c >= 0 && c - last_c != 3) bad_gap++;
        last_c = c;
        g++;
      end
    end
    if_req = 1'b0;
    d_req = 1'b0;
    checks++; if (g != 4 || got !== want) begin
      errors++; $display("FAIL arb_order got %0d grants order %b want 4 grants %b (bit=1 data)", g, got, want); end
    checks++; if (bad_gap != 0) begin errors++; $display("FAIL arb_spacing got %0d bad gaps want 0", bad_gap); end
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_wr = 1'b0; d_size = 2'b00; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    test_reset();
    test_fetch();
    test_concurrent();
    test_lanes();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
